pixel_labeler_stream: RTL

PIXEL_LABELER_STREAM -- requirements
Module: pixel_labeler_stream

---
 rtl/pixel_labeler_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pixel_labeler_stream.sv
// Streaming first-pass connected-component labeler: assigns provisional labels to motion
// pixels in raster order and reports new-label allocations and label equivalences.
module pixel_labeler_stream #(
  parameter int LABEL_WIDTH  = 8,
  parameter int IMG_WIDTH    = 320,
  parameter int CONNECTIVITY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   sof,
  input  logic                   motion_pixel,
  output logic                   out_valid,
  output logic [LABEL_WIDTH-1:0] current_label,
  output logic                   new_label_valid,
  output logic [LABEL_WIDTH-1:0] new_label_value,
  output logic                   merge0_valid,
  output logic [LABEL_WIDTH-1:0] merge0_a,
  output logic [LABEL_WIDTH-1:0] merge0_b,
  output logic                   merge1_valid,
  output logic [LABEL_WIDTH-1:0] merge1_a,
  output logic [LABEL_WIDTH-1:0] merge1_b,
  output logic                   labels_exhausted
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [LABEL_WIDTH-1:0] MAX_LABEL = '1;
  localparam logic [LABEL_WIDTH-1:0] FIRST_LABEL = LABEL_WIDTH'(1);

  generate
    if (CONNECTIVITY != 4 && CONNECTIVITY != 8) begin : g_bad_connectivity
      $error("pixel_labeler_stream: CONNECTIVITY must be 4 or 8");
    end
  endgenerate

  logic [CW-1:0]          col;
  logic [15:0]            row;
  logic [LABEL_WIDTH-1:0] next_label;
  logic [LABEL_WIDTH-1:0] prev_label;
  logic [LABEL_WIDTH-1:0] prev_top;
  logic [LABEL_WIDTH-1:0] line_buf [IMG_WIDTH];

  logic [CW-1:0]          eff_col, tr_idx;
  logic [15:0]            eff_row;
  logic                   eff_row0, exh_eff, alloc, wrap;
  logic [LABEL_WIDTH-1:0] eff_next, left, top, top_left, top_right;
  logic [LABEL_WIDTH-1:0] min_lbl, d0, d1, label;
  logic [3:0][LABEL_WIDTH-1:0] nbr;

  // Smallest neighbour label strictly above t; 0 when none qualifies.
  function automatic logic [LABEL_WIDTH-1:0] min_above(input logic [3:0][LABEL_WIDTH-1:0] v,
                                                      input logic [LABEL_WIDTH-1:0] t);
    logic [LABEL_WIDTH-1:0] best;
    best = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] > t && (best == '0 || v[i] < best)) best = v[i];
    end
    return best;
  endfunction

  // A pixel flagged sof restarts position and allocator for itself, not only for later pixels.
  always_comb begin
    eff_col   = sof ? '0 : col;
    eff_row   = sof ? '0 : row;
    eff_row0  = (eff_row == '0);
    eff_next  = sof ? FIRST_LABEL : next_label;
    exh_eff   = sof ? 1'b0 : labels_exhausted;
    wrap      = (eff_col == LAST_COL);
    tr_idx    = wrap ? eff_col : eff_col + CW'(1);
    left      = (eff_col != '0) ? prev_label : '0;
    top       = eff_row0 ? '0 : line_buf[eff_col];
    top_left  = (eff_row0 || eff_col == '0) ? '0 : prev_top;
    top_right = (eff_row0 || wrap) ? '0 : line_buf[tr_idx];
    if (CONNECTIVITY == 8) nbr = {top_right, top, top_left, left};
    else                   nbr = {{(2*LABEL_WIDTH){1'b0}}, top, left};
    min_lbl = min_above(nbr, '0);
    d0      = min_above(nbr, min_lbl);
    d1      = (d0 != '0) ? min_above(nbr, d0) : '0;
    alloc   = motion_pixel && (min_lbl == '0) && !exh_eff;
    if (!motion_pixel)       label = '0;
    else if (min_lbl != '0)  label = min_lbl;
    else if (alloc)          label = eff_next;
    else                     label = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col              <= '0;
      row              <= '0;
      next_label       <= FIRST_LABEL;
      labels_exhausted <= 1'b0;
      prev_label       <= '0;
      prev_top         <= '0;
      out_valid        <= 1'b0;
      current_label    <= '0;
      new_label_valid  <= 1'b0;
      new_label_value  <= '0;
      merge0_valid     <= 1'b0;
      merge0_a         <= '0;
      merge0_b         <= '0;
      merge1_valid     <= 1'b0;
      merge1_a         <= '0;
      merge1_b         <= '0;
    end else begin
      out_valid       <= in_valid;
      current_label   <= in_valid ? label : '0;
      new_label_valid <= in_valid && alloc;
      new_label_value <= (in_valid && alloc) ? eff_next : '0;
      merge0_valid    <= in_valid && motion_pixel && (d0 != '0);
      merge0_a        <= (in_valid && motion_pixel && d0 != '0) ? min_lbl : '0;
      merge0_b        <= (in_valid && motion_pixel) ? d0 : '0;
      merge1_valid    <= in_valid && motion_pixel && (d1 != '0);
      merge1_a        <= (in_valid && motion_pixel && d1 != '0) ? min_lbl : '0;
      merge1_b        <= (in_valid && motion_pixel) ? d1 : '0;
      if (in_valid) begin
        prev_label       <= label;
        prev_top         <= top;
        col              <= wrap ? '0 : eff_col + CW'(1);
        row              <= (wrap && eff_row != '1) ? eff_row + 16'd1 : eff_row;
        next_label       <= (alloc && eff_next != MAX_LABEL) ? eff_next + FIRST_LABEL : eff_next;
        labels_exhausted <= exh_eff || (alloc && eff_next == MAX_LABEL);
      end
    end
  end

  // Line buffer needs no reset: row-0 masking hides stale contents.
  always_ff @(posedge clk) begin
    if (in_valid) line_buf[eff_col] <= label;
  end

endmodule
